// File: rtl/div_pkg.sv
// Shared types and sizing for the multicycle signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient on lo, remainder on hi,
// one restoring step per clock, sign fix-up in a final cycle.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             divControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state, state_nxt;
  logic [WIDTH-1:0] mag_b, rem, quot;
  logic             neg_q, neg_r;
  logic [CNT_W-1:0] cnt;
  logic             div0_p0;
  logic [WIDTH:0]   rem_sh, rem_sub;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // Magnitude of a two's-complement value; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return cond_neg($unsigned(v), v[WIDTH-1]);
  endfunction

  // One extra bit on the trial subtract: its borrow is the rem < |b| decision.
  always_comb begin
    rem_sh  = {rem, quot[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, mag_b};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (divControl && (b != '0)) state_nxt = CALC;
      CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Busy is withheld until the first restoring step has been taken.
  always_comb begin
    busy = ((state == CALC) && (cnt != '0)) || (state == FIX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_b   <= '0;
      rem     <= '0;
      quot    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      div0_p0 <= 1'b0;
      div0    <= 1'b0;
    end else begin
      done    <= 1'b0;
      div0_p0 <= 1'b0;
      div0    <= div0_p0;
      case (state)
        IDLE: begin
          if (divControl) begin
            if (b == '0) begin
              div0_p0 <= 1'b1;
            end else begin
              mag_b <= mag(b);
              quot  <= mag(a);
              rem   <= '0;
              neg_r <= a[WIDTH-1];
              neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
              cnt   <= '0;
            end
          end
        end
        CALC: begin
          if (!rem_sub[WIDTH]) begin
            rem  <= rem_sub[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b1};
          end else begin
            rem  <= rem_sh[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          lo   <= cond_neg(quot, neg_q);
          hi   <= cond_neg(rem, neg_r);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a result scoreboard and cycle-accurate handshake checks.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        divControl;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, div0;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  int k_done, n_div0, n_busy, busy1, busy_dn, div0_k1;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .divControl (divControl),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div0       (div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: truncating signed division in 64 bits, then wrapped to 32.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    exp_t   r;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    r.lo = 32'(sx / sy);
    r.hi = 32'(sx % sy);
    return r;
  endfunction

  // Drives a start pulse sampled at edge E0; returns 1 time unit after E0.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input bit push);
    @(negedge clk);
    a          = x;
    b          = y;
    divControl = 1'b1;
    if (push) sb.push_back(model(x, y));
    @(posedge clk);
    #1;
    divControl = 1'b0;
  endtask

  // Observes edges E1..E<max_k>; optionally injects a start with other operands before edge inj_k.
  task automatic watch(input int inj_k, input int max_k);
    k_done  = 0;
    n_div0  = 0;
    n_busy  = 0;
    busy1   = 0;
    busy_dn = 0;
    div0_k1 = 0;
    for (int k = 1; k <= max_k; k++) begin
      if (k == inj_k) begin
        divControl = 1'b1;
        a          = 32'd55;
        b          = 32'd0;
      end
      @(posedge clk);
      #1;
      divControl = 1'b0;
      if (div0) n_div0++;
      if (busy) n_busy++;
      if (k == 1) begin
        busy1   = int'(busy);
        div0_k1 = int'(div0);
      end
      if (done) begin
        k_done  = k;
        busy_dn = int'(busy);
        break;
      end
    end
  endtask

  task automatic finish_div(input string tag);
    exp_t e;
    check({tag, "_latency"}, 32'(k_done), 32'd33);
    check({tag, "_busy_rise"}, 32'(busy1), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy_dn), 32'd0);
    check({tag, "_no_div0"}, 32'(n_div0), 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_lo"}, lo, e.lo);
      check({tag, "_hi"}, hi, e.hi);
    end else begin
      check({tag, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
    end
    @(posedge clk);
    #1;
    check({tag, "_done_clears"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    divControl = 1'b0;
    a          = '0;
    b          = '0;
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_flags", {29'd0, busy, done, div0}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    issue(32'd7, 32'd2, 1'b1);
    watch(0, 40);
    finish_div("p7_d2");
    check("p7_d2_lo_const", lo, 32'd3);
    check("p7_d2_hi_const", hi, 32'd1);

    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    watch(0, 40);
    finish_div("m7_d2");
    check("m7_d2_lo_const", lo, 32'hFFFF_FFFD);
    check("m7_d2_hi_const", hi, 32'hFFFF_FFFF);

    issue(32'd7, 32'hFFFF_FFFE, 1'b1);
    watch(0, 40);
    finish_div("p7_dm2");
    check("p7_dm2_lo_const", lo, 32'hFFFF_FFFD);
    check("p7_dm2_hi_const", hi, 32'd1);

    // Re-establish lo=3, hi=1 before the zero-divisor case.
    issue(32'd7, 32'd2, 1'b1);
    watch(0, 40);
    finish_div("pre_div0");

    issue(32'd5, 32'd0, 1'b0);
    check("div0_not_at_e0", 32'(div0), 32'd0);
    watch(0, 36);
    check("div0_at_e1", 32'(div0_k1), 32'd1);
    check("div0_one_cycle", 32'(n_div0), 32'd1);
    check("div0_no_busy", 32'(n_busy), 32'd0);
    check("div0_no_done", 32'(k_done), 32'd0);
    check("div0_hold_lo", lo, 32'd3);
    check("div0_hold_hi", hi, 32'd1);

    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    watch(0, 40);
    finish_div("ovf");
    check("ovf_lo_const", lo, 32'h8000_0000);
    check("ovf_hi_const", hi, 32'd0);

    issue(32'd100, 32'd7, 1'b1);
    watch(10, 40);
    finish_div("interf");
    check("interf_lo_const", lo, 32'd14);
    check("interf_hi_const", hi, 32'd2);

    issue(32'd1000, 32'd3, 1'b0);
    watch(0, 19);
    check("abort_no_early_done", 32'(k_done), 32'd0);
    @(posedge clk);
    reset = 1'b1;
    #1;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_div0", 32'(div0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    watch(0, 40);
    check("abort_never_done", 32'(k_done), 32'd0);
    check("abort_stays_idle", 32'(n_busy), 32'd0);

    issue(32'd9, 32'd3, 1'b1);
    watch(0, 40);
    finish_div("p9_d3");
    check("p9_d3_lo_const", lo, 32'd3);
    check("p9_d3_hi_const", hi, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multicycle signed 32-bit divider for the multicycle MIPS datapath. The control FSM drives it with a one-cycle `divControl` start pulse. It returns the quotient on `lo` and the remainder on `hi`. The control FSM latches these into the LO/HI registers via `lodivControl`/`hidivControl`. A zero divisor raises the `div0` exception input of the control unit instead of producing a result.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width in bits.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `divControl`  in  1  start pulse; sampled only in IDLE.
- `a`  in  WIDTH  dividend, two's complement (register A).
- `b`  in  WIDTH  divisor, two's complement (register B).
- `hi`  out  WIDTH  remainder.
- `lo`  out  WIDTH  quotient.
- `busy`  out  1  high in CALC and FIX.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid.
- `div0`  out  1  one-cycle pulse; divisor was zero.

## Operation
- FSM states: IDLE, CALC, FIX.
- **IDLE, `divControl`=1, `b`≠0:**
  - latch |a| and |b| as unsigned magnitudes;
  - latch sign(a) and sign(a)^sign(b);
  - clear the WIDTH-bit partial remainder;
  - clear the step counter;
  - go to CALC.
- **IDLE, `divControl`=1, `b`=0:**
  - assert `div0` for one cycle;
  - `hi`/`lo` hold their previous values;
  - stay in IDLE.
- **CALC, one restoring step per edge:**
  - shift {rem, quot} left by 1, shifting in the next dividend MSB;
  - if rem ≥ |b|: rem −= |b| and set quot LSB;
  - the compare uses WIDTH+1 bits so |b| = 2^31 is handled;
  - after step WIDTH−1, go to FIX.
- **FIX:**
  - `lo` = quot, negated if the operand signs differed;
  - `hi` = rem, negated if the dividend was negative (remainder takes the dividend's sign, truncating division);
  - assert `done`;
  - go to IDLE.
- `divControl` in CALC or FIX is ignored; no queueing.
- Overflow case −2^31 / −1: `lo` = 0x80000000, `hi` = 0. This wraps with no exception and no `div0`.
- |a| of −2^31 is 0x80000000 treated as unsigned; no special path.
- `a` and `b` are only sampled at start; later changes do not affect the operation.

## Timing
- Reset values: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div0`=0, counter 0.
- Cycle sequence, with start sampled at edge E0:
  - CALC steps occur at E1..E_WIDTH;
  - FIX registers `hi`/`lo` and sets `done` at E_WIDTH+1 (E33);
  - `done` clears at E34.
- Latency: WIDTH+1 edges from start to `done`.
- Back-to-back issue: a new start is accepted at E34 at the earliest.
- `busy` rises at E1 and falls at E33.
- `div0` rises at E1 and falls at E2; `busy` stays 0 throughout.
- `hi`/`lo` change only at the FIX edge and otherwise hold.
- Reset asserted mid-CALC or mid-FIX:
  - immediate return to reset values;
  - no `done`;
  - the next start after reset behaves normally.

## Structure
- Shared package `div_pkg`:
  - state enum {IDLE, CALC, FIX};
  - `DIV_WIDTH` = 32;
  - counter width = $clog2(DIV_WIDTH).
- No sub-module needed. The restoring step (shift, subtract, compare) is small enough to stay inline in one sequential block plus one combinational next-state block.

## Test plan
- 7 / 2:
  - `lo`=3, `hi`=1;
  - `done` high exactly in the cycle after E33;
  - `busy` low after E33.
- −7 / 2: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- 7 / −2: `lo`=0xFFFFFFFD, `hi`=1.
- 5 / 0 with prior result `lo`=3, `hi`=1:
  - `div0` pulses one cycle at E1;
  - `busy` and `done` never assert;
  - `hi`/`lo` stay 1/3.
- 0x80000000 / 0xFFFFFFFF:
  - `lo`=0x80000000, `hi`=0;
  - no `div0`.
- Interference and reset:
  - start 100/7, pulse `divControl` with other operands at E10: ignored, result is `lo`=14, `hi`=2;
  - assert reset at E20 of a second divide: all outputs go to 0 and there is no `done`;
  - then 9/3 gives `lo`=3, `hi`=0.
